// File: rtl/mul_arbiter_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// State encoding, datapath widths and the cyclic priority picker.
package mul_arbiter_pkg;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 17;
  localparam int MAX_N  = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

  // First set bit of req searching cyclically from ptr+1 over n requesters.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input int n);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (i <= n) begin
        cand = IDX_W'((int'(ptr) + i) % n);
        if (!found && req[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_arbiter_mul.sv
// 8x8 shift-add sequential multiplier: start loads operands, eight steps
// follow, fin is high once all steps are done and O holds the product.
module mul
  import mul_arbiter_pkg::*;
(
  input  logic              ck,
  input  logic              start,
  input  logic [MUL_W-1:0]  A,
  input  logic [MUL_W-1:0]  B,
  output logic [PROD_W-1:0] O,
  output logic              fin
);

  logic [2*MUL_W-1:0] mcand;
  logic [MUL_W-1:0]   mplier;
  logic [PROD_W-1:0]  acc;
  logic [3:0]         step;

  // NOTE: no reset here on purpose; start fully reloads every register, so
  // nothing is observed before the first start reaches it.
  always_ff @(posedge ck) begin
    if (start) begin
      mcand  <= {{MUL_W{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      step   <= '0;
    end else if (step != 4'(MUL_W)) begin
      if (mplier[0]) acc <= acc + PROD_W'(mcand);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 4'd1;
    end
  end

  assign O   = acc;
  assign fin = (step == 4'(MUL_W));

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among N requesters,
// with operand latching, start/fin sequencing and a fin watchdog.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [MUL_W*N-1:0]  a_in,
  input  logic [MUL_W*N-1:0]  b_in,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        done,
  output logic [PROD_W-1:0]   result,
  output logic                err,
  output logic                busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, owner, grant;
  logic [MUL_W-1:0]   a_lat, b_lat;
  logic [WD_W-1:0]    wd;
  logic               timeout;
  logic               mul_start, mul_fin;
  logic [PROD_W-1:0]  mul_o;

  assign grant   = rr_pick(MAX_N'(req), ptr, N);
  assign timeout = (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: default first so every path assigns state_nx and no latch forms.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = START;
      START:   state_nx = BUSY;
      BUSY:    if (mul_fin || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IDX_W'(N - 1);
      owner  <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      wd     <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          owner <= grant;
          ptr   <= grant;
          a_lat <= a_in[int'(grant)*MUL_W +: MUL_W];
          b_lat <= b_in[int'(grant)*MUL_W +: MUL_W];
        end
        START: wd <= '0;
        BUSY: begin
          wd <= wd + WD_W'(1);
          if (mul_fin) begin
            result <= mul_o;
            err    <= 1'b0;
          end else if (timeout) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        DONE: begin
          result <= '0;
          err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mul_start = (state == START);
  assign ack       = (state == START) ? N'(onehot(owner)) : '0;
  assign done      = (state == DONE)  ? N'(onehot(owner)) : '0;
  assign busy      = (state != IDLE);

  mul u_mul (
    .ck    (ck),
    .start (mul_start),
    .A     (a_lat),
    .B     (b_lat),
    .O     (mul_o),
    .fin   (mul_fin)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a transaction-level timing model is
// compared against the outputs every cycle, plus directed literal checks.
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  logic              ck = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [8*N-1:0]    a_in = '0;
  logic [8*N-1:0]    b_in = '0;
  logic [N-1:0]      ack, done;
  logic [PROD_W-1:0] result;
  logic              err, busy;

  mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .done(done), .result(result), .err(err), .busy(busy)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int own;
    int res;
    bit er;
    int cyc;
  } ev_t;
  ev_t dlog[$];

  // Model: one job at a time; grant in cycle g, ack at g+1, done at g+lat.
  bit stub = 1'b0;
  bit job_v = 1'b0;
  int job_g, job_end, job_own, job_prod;
  bit job_to;
  int last_own = N - 1;

  always @(negedge ck) begin
    logic [N-1:0] e_ack, e_done;
    int  e_res;
    bit  e_err, e_busy;
    ev_t ev;
    e_ack = '0; e_done = '0; e_res = 0; e_err = 1'b0; e_busy = 1'b0;
    if (!rst_n) begin
      job_v    = 1'b0;
      last_own = N - 1;
    end else if (job_v && cyc > job_g && cyc <= job_end) begin
      e_busy = 1'b1;
      if (cyc == job_g + 1) e_ack[job_own] = 1'b1;
      if (cyc == job_end) begin
        e_done[job_own] = 1'b1;
        e_res = job_to ? 0 : job_prod;
        e_err = job_to;
      end
    end
    check("ack", 32'(ack), 32'(e_ack));
    check("done", 32'(done), 32'(e_done));
    check("result", 32'(result), e_res);
    check("err", 32'(err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));

    if (done != '0) begin
      ev.own = -1;
      for (int i = 0; i < N; i++) if (done[i]) ev.own = i;
      ev.res = int'(result);
      ev.er  = err;
      ev.cyc = cyc;
      dlog.push_back(ev);
    end

    if (rst_n && (!job_v || cyc > job_end) && req != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(last_own + k) % N]) begin
          job_own = (last_own + k) % N;
          break;
        end
      end
      job_g    = cyc;
      job_prod = int'(a_in[8*job_own +: 8]) * int'(b_in[8*job_own +: 8]);
      job_to   = stub;
      job_end  = cyc + (stub ? TIMEOUT + 2 : 11);
      last_own = job_own;
      job_v    = 1'b1;
    end
  end

  task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input int exp_res, input bit exp_err, input int lat);
    int t0, n0, ack_c;
    bit got;
    @(posedge ck); #1;
    n0 = dlog.size();
    t0 = cyc;
    ack_c = -1;
    req[idx] = 1'b1;
    a_in[8*idx +: 8] = a;
    b_in[8*idx +: 8] = b;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge ck); #1;
      if (ack[idx]) begin
        if (ack_c < 0) ack_c = cyc;
        req[idx] = 1'b0;
      end
      if (dlog.size() > n0) got = 1'b1;
    end
    req[idx] = 1'b0;
    check("single_done_seen", 32'(got), 1);
    check("single_ack_cycle", ack_c, t0 + 1);
    if (got) begin
      check("single_owner", dlog[n0].own, idx);
      check("single_result", dlog[n0].res, exp_res);
      check("single_err", 32'(dlog[n0].er), 32'(exp_err));
      check("single_done_cycle", dlog[n0].cyc, t0 + lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, t0;
    int exp_c[4];
    exp_c = '{6, 12, 20, 30};

    repeat (3) @(posedge ck);
    #1 rst_n = 1'b1;

    single(0, 8'd13, 8'd11, 143, 1'b0, 11);
    single(1, 8'd255, 8'd255, 65025, 1'b0, 11);
    single(2, 8'd0, 8'd200, 0, 1'b0, 11);
    single(3, 8'd1, 8'd255, 255, 1'b0, 11);

    // Contention: all four at once, served in order 0..3.
    @(posedge ck); #1;
    n0 = dlog.size();
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      a_in[8*i +: 8] = 8'(i + 2);
      b_in[8*i +: 8] = 8'(i + 3);
    end
    req = '1;
    for (int k = 0; k < 80 && dlog.size() < n0 + 4; k++) begin
      @(posedge ck); #1;
      req = req & ~ack;
    end
    req = '0;
    check("cont_count", dlog.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      if (dlog.size() > n0 + i) begin
        check("cont_owner", dlog[n0+i].own, i);
        check("cont_result", dlog[n0+i].res, exp_c[i]);
        check("cont_cycle", dlog[n0+i].cyc, t0 + 11 + 12 * i);
      end
    end

    // Fairness: 0 and 2 held continuously, random operands every cycle.
    @(posedge ck); #1;
    n0 = dlog.size();
    req = 4'b0101;
    for (int k = 0; k < 120 && dlog.size() < n0 + 6; k++) begin
      @(posedge ck); #1;
      for (int i = 0; i < N; i++) begin
        a_in[8*i +: 8] = 8'($urandom);
        b_in[8*i +: 8] = 8'($urandom);
      end
    end
    req = '0;
    check("fair_count", dlog.size() - n0, 6);
    for (int i = 0; i < 6; i++) begin
      if (dlog.size() > n0 + i) check("fair_owner", dlog[n0+i].own, (i % 2 == 0) ? 0 : 2);
    end
    repeat (14) @(posedge ck);

    // Reset mid-job: dropped job must never complete.
    @(posedge ck); #1;
    n0 = dlog.size();
    t0 = cyc;
    a_in[7:0] = 8'd21;
    b_in[7:0] = 8'd4;
    req[0] = 1'b1;
    while (cyc < t0 + 5) begin
      @(posedge ck); #1;
      if (ack[0]) req[0] = 1'b0;
    end
    req[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge ck);
    check("rst_no_done", dlog.size() - n0, 0);
    single(1, 8'd7, 8'd9, 63, 1'b0, 11);

    // Timeout: fin held low, then a normal job afterwards.
    stub = 1'b1;
    force dut.mul_fin = 1'b0;
    single(2, 8'd5, 8'd6, 0, 1'b1, TIMEOUT + 2);
    release dut.mul_fin;
    stub = 1'b0;
    single(2, 8'd5, 8'd6, 30, 1'b0, 11);

    // Random traffic.
    n0 = dlog.size();
    for (int k = 0; k < 400; k++) begin
      @(posedge ck); #1;
      for (int i = 0; i < N; i++) begin
        a_in[8*i +: 8] = 8'($urandom);
        b_in[8*i +: 8] = 8'($urandom);
        if (req[i] && ack[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i])     req[i] = ($urandom_range(0, 3) == 0);
      end
    end
    req = '0;
    for (int k = 0; k < 40 && busy; k++) @(posedge ck);
    #1;
    check("drain_idle", 32'(busy), 0);
    check("random_progress", 32'(dlog.size() - n0 >= 20), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
